fir_stream_driver: RTL and testbench
====================================

# fir_stream_driver

Initiator-side companion of the block-mode FIR filter. It packs a serial 16-bit sample stream into one SAMPLES_NUM-sample frame and fires the filter's start/busy/done handshake. It then captures the 32-bit saturated results, scales them back to 16-bit and emits them serially. It sits between the audio sample source/sink and the FIR core, so the rest of the design can use a plain valid/ready stream.

## Interface
Parameters:
- SAMPLES_NUM, 4: samples per frame; must match the filter instance (1..8).
- OUT_SHIFT, 15: arithmetic right shift applied to each 32-bit result (Q15 coefficients); range 1..16.

Ports:
- clkIn  in  1  single clock; all logic on posedge.
- nResetIn  in  1  reset, asynchronous, active-low.
- sampleIn  in  16  signed input sample.
- sampleValidIn  in  1  sampleIn valid.
- sampleReadyOut  out  1  driver accepts a sample this cycle.
- firStartOut  out  1  start request to the filter.
- firBusyIn  in  1  filter busy.
- firDoneIn  in  1  filter one-cycle done pulse.
- firDataOut  out  16*SAMPLES_NUM  packed frame to the filter.
- firDataIn  in  32*SAMPLES_NUM  packed results from the filter.
- resultOut  out  16  signed scaled result.
- resultValidOut  out  1  resultOut valid.
- resultReadyIn  in  1  sink accepts resultOut.

## Operation
- FSM states: COLLECT, START, WAIT, EMIT. Reset state is COLLECT.
- COLLECT:
  - sampleReadyOut=1.
  - Each valid&ready handshake writes sampleIn to slot idx, where slot k occupies firDataOut[16k+15:16k]. Slot 0 holds the oldest sample.
  - idx increments per handshake.
  - The handshake that fills slot SAMPLES_NUM-1 clears idx and moves to START.
- START:
  - firStartOut = !firBusyIn (combinational). It is held off while the filter is still busy.
  - On the edge where firStartOut=1, go to WAIT.
  - firDataOut is stable from entering START until firDoneIn is seen.
- WAIT:
  - Outputs idle.
  - On the edge where firDoneIn=1, register firDataIn into the result register and go to EMIT.
- EMIT:
  - resultValidOut=1.
  - resultOut = scale(result word k). Word k = firDataIn[32*(SAMPLES_NUM-k)-1 -: 32], so the oldest output comes first.
  - k advances on valid&ready. resultOut is stable while ready is low.
  - After the handshake on word SAMPLES_NUM-1, clear k and return to COLLECT.
- Scale function, computed in 33-bit signed:
  - v = sign-extended word, then v >>> OUT_SHIFT.
  - Saturate to [-32768, 32767], i.e. 0x8000 / 0x7FFF.
- Throughput: no overlap between frames. sampleReadyOut=0 in START, WAIT and EMIT.
- firDoneIn outside WAIT is ignored. firBusyIn is only consulted in START.

## Timing
- Reset values of outputs:
  - sampleReadyOut=1 once nResetIn deasserts (state COLLECT).
  - firStartOut=0, resultValidOut=0, firDataOut=0, resultOut=0.
  - idx=0, k=0.
- Reset asserted mid-frame aborts immediately. Partial samples and captured results are discarded, and no start is issued.
- Last sample accepted at edge E: firStartOut is high in the cycle after E (if firBusyIn=0), and the filter samples start at E+1.
- firDoneIn high at edge D: resultValidOut is high in the cycle after D.
- With resultReadyIn=1 throughout, EMIT lasts exactly SAMPLES_NUM cycles. sampleReadyOut returns high the cycle after the last handshake.
- START with firBusyIn=1: firStartOut stays 0 and the state holds until firBusyIn falls.

## Configuration
- FIR_STREAM_ROUND_EN
  - Defined: round half-up. Compute v + (1<<(OUT_SHIFT-1)) in 33 bits, then shift, then saturate.
  - Undefined: truncation toward negative infinity (shift only).

## Structure
- Package fir_stream_pkg:
  - IN_SAMPLE_WIDTH=16, OUT_SAMPLE_WIDTH=32.
  - FSM state enum typedef.
  - A signed 33-bit intermediate typedef.
- Sub-module fir_result_scaler: combinational round/shift/saturate of one 32-bit word. It holds the only use of FIR_STREAM_ROUND_EN.

## Test plan
All scenarios use SAMPLES_NUM=4, OUT_SHIFT=15.
- Frame packing: feed 0x0001, 0x0002, 0x0003, 0x0004 back-to-back -> firDataOut=0x0004_0003_0002_0001; firStartOut pulses one cycle; sampleReadyOut=0 until EMIT finishes.
- Result order and scaling: firDataIn words (MSB→LSB) 0x00008000, 0x7FFFFFFF, 0x80000000, 0x00010000 with done pulse -> resultOut 0x0001, 0x7FFF, 0x8000, 0x0002.
- Rounding: word 0x00004000 and 0xFFFFFFFF -> 0x0000 and 0xFFFF without FIR_STREAM_ROUND_EN; 0x0001 and 0x0000 with it.
- Busy hold-off: firBusyIn=1 for 5 cycles on entering START -> firStartOut=0 for those cycles, then exactly one pulse.
- Backpressure: resultReadyIn toggles 1/0 -> each word held stable while ready=0, emitted exactly once, in order; firDoneIn pulses outside WAIT have no effect.
- Reset mid-operation: assert nResetIn after 2 samples and again during EMIT -> all outputs return to reset values; the next 4 samples form a clean frame.

Source files
------------

// File: rtl/fir_stream_pkg.sv
// Shared widths and types for the FIR stream driver.
// The FIR_STREAM_ROUND_EN build option is handled entirely inside fir_result_scaler.
package fir_stream_pkg;

  localparam int unsigned IN_SAMPLE_WIDTH  = 16;
  localparam int unsigned OUT_SAMPLE_WIDTH = 32;

  typedef enum logic [1:0] {
    StCollect,
    StStart,
    StWait,
    StEmit
  } fsm_state_e;

  // 33-bit signed intermediate: a 32-bit result plus headroom for the rounding bias.
  typedef logic signed [OUT_SAMPLE_WIDTH:0] acc_t;

endpackage

// File: rtl/fir_stream_driver_if.sv
// Sample stream, FIR handshake and result stream of the FIR stream driver.
// The master modport is the driver's view; slave is the surrounding logic.
interface fir_stream_driver_if #(
  parameter int unsigned SAMPLES_NUM = 4
);
  import fir_stream_pkg::*;

  logic [IN_SAMPLE_WIDTH-1:0]              sampleIn;
  logic                                    sampleValidIn;
  logic                                    sampleReadyOut;
  logic                                    firStartOut;
  logic                                    firBusyIn;
  logic                                    firDoneIn;
  logic [IN_SAMPLE_WIDTH*SAMPLES_NUM-1:0]  firDataOut;
  logic [OUT_SAMPLE_WIDTH*SAMPLES_NUM-1:0] firDataIn;
  logic [IN_SAMPLE_WIDTH-1:0]              resultOut;
  logic                                    resultValidOut;
  logic                                    resultReadyIn;

  modport master (
    input  sampleIn, sampleValidIn, firBusyIn, firDoneIn, firDataIn, resultReadyIn,
    output sampleReadyOut, firStartOut, firDataOut, resultOut, resultValidOut
  );

  modport slave (
    output sampleIn, sampleValidIn, firBusyIn, firDoneIn, firDataIn, resultReadyIn,
    input  sampleReadyOut, firStartOut, firDataOut, resultOut, resultValidOut
  );

endinterface

// File: rtl/fir_result_scaler.sv
// Combinational shift/saturate of one 32-bit filter result down to 16 bits.
// Define FIR_STREAM_ROUND_EN for round half-up; otherwise truncates toward -inf.
module fir_result_scaler
  import fir_stream_pkg::*;
#(
  parameter int unsigned OUT_SHIFT = 15
) (
  input  logic [OUT_SAMPLE_WIDTH-1:0] word_i,
  output logic [IN_SAMPLE_WIDTH-1:0]  result_o
);

  localparam acc_t MaxVal = 33'sd32767;
  localparam acc_t MinVal = -33'sd32768;

  acc_t ext;
  acc_t biased;
  acc_t shifted;

  always_comb begin
    ext = acc_t'(signed'(word_i));
`ifdef FIR_STREAM_ROUND_EN
    biased = ext + (acc_t'(1) <<< (OUT_SHIFT - 1));
`else
    biased = ext;
`endif
    shifted = biased >>> OUT_SHIFT;
    if (shifted > MaxVal) begin
      result_o = 16'h7fff;
    end else if (shifted < MinVal) begin
      result_o = 16'h8000;
    end else begin
      result_o = shifted[IN_SAMPLE_WIDTH-1:0];
    end
  end

endmodule

// File: rtl/fir_stream_driver.sv
// Packs a serial sample stream into one FIR frame, runs the start/busy/done handshake,
// then streams the scaled results back out. Rounding mode: FIR_STREAM_ROUND_EN.
module fir_stream_driver
  import fir_stream_pkg::*;
#(
  parameter int unsigned SAMPLES_NUM = 4,
  parameter int unsigned OUT_SHIFT   = 15
) (
  input logic               clkIn,
  input logic               nResetIn,
  fir_stream_driver_if.master bus
);

  localparam int unsigned FrameW  = IN_SAMPLE_WIDTH * SAMPLES_NUM;
  localparam int unsigned ResultW = OUT_SAMPLE_WIDTH * SAMPLES_NUM;
  localparam logic [2:0]  LastIdx = 3'(SAMPLES_NUM - 1);

  fsm_state_e                  state_q, state_d;
  logic [2:0]                  idx_q, idx_d;
  logic [2:0]                  k_q, k_d;
  logic [FrameW-1:0]           frame_q, frame_d;
  logic [ResultW-1:0]          result_q, result_d;
  logic [OUT_SAMPLE_WIDTH-1:0] word;
  logic [IN_SAMPLE_WIDTH-1:0]  scaled;

  // Word 0 sits in the top of the result bus, so the oldest output leaves first.
  assign word = result_q[OUT_SAMPLE_WIDTH * (SAMPLES_NUM - 1 - 32'(k_q)) +: OUT_SAMPLE_WIDTH];
  assign bus.firDataOut = frame_q;

  fir_result_scaler #(
    .OUT_SHIFT (OUT_SHIFT)
  ) u_scaler (
    .word_i   (word),
    .result_o (scaled)
  );

  always_ff @(posedge clkIn or negedge nResetIn) begin
    if (!nResetIn) begin
      state_q  <= StCollect;
      idx_q    <= '0;
      k_q      <= '0;
      frame_q  <= '0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      k_q      <= k_d;
      frame_q  <= frame_d;
      result_q <= result_d;
    end
  end

  always_comb begin
    state_d            = state_q;
    idx_d              = idx_q;
    k_d                = k_q;
    frame_d            = frame_q;
    result_d           = result_q;
    bus.sampleReadyOut = 1'b0;
    bus.firStartOut    = 1'b0;
    bus.resultValidOut = 1'b0;
    bus.resultOut      = '0;

    unique case (state_q)
      StCollect: begin
        bus.sampleReadyOut = 1'b1;
        if (bus.sampleValidIn) begin
          frame_d[IN_SAMPLE_WIDTH * 32'(idx_q) +: IN_SAMPLE_WIDTH] = bus.sampleIn;
          if (idx_q == LastIdx) begin
            idx_d   = '0;
            state_d = StStart;
          end else begin
            idx_d = idx_q + 3'd1;
          end
        end
      end
      StStart: begin
        bus.firStartOut = !bus.firBusyIn;
        if (!bus.firBusyIn) begin
          state_d = StWait;
        end
      end
      StWait: begin
        if (bus.firDoneIn) begin
          result_d = bus.firDataIn;
          state_d  = StEmit;
        end
      end
      StEmit: begin
        bus.resultValidOut = 1'b1;
        bus.resultOut      = scaled;
        if (bus.resultReadyIn) begin
          if (k_q == LastIdx) begin
            k_d     = '0;
            state_d = StCollect;
          end else begin
            k_d = k_q + 3'd1;
          end
        end
      end
    endcase
  end

endmodule

// File: tb/tb_fir_stream_driver.sv
// Scoreboard bench for fir_stream_driver: directed frames and filter results, with a
// monitor that checks every start (frame contents) and every result handshake.
module tb_fir_stream_driver;
  import fir_stream_pkg::*;

  localparam int unsigned N     = 4;
  localparam int unsigned SHIFT = 15;

  logic clkIn    = 1'b0;
  logic nResetIn = 1'b0;

  always #5 clkIn = ~clkIn;

  fir_stream_driver_if #(.SAMPLES_NUM(N)) bus ();

  fir_stream_driver #(
    .SAMPLES_NUM (N),
    .OUT_SHIFT   (SHIFT)
  ) dut (
    .clkIn    (clkIn),
    .nResetIn (nResetIn),
    .bus      (bus)
  );

  int          errors    = 0;
  int          checks    = 0;
  int          start_cnt = 0;
  logic [63:0] exp_frame_q[$];
  logic [15:0] exp_res_q[$];
  logic        hold_pend = 1'b0;
  logic [15:0] hold_val  = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    errors++;
    $display("FAIL %s: event did not occur as expected", name);
  endtask

  // Monitor: frames at start, results at each valid&ready, stability under backpressure.
  initial begin
    forever begin
      @(negedge clkIn);
      if (!nResetIn) begin
        hold_pend = 1'b0;
      end else begin
        if (bus.firStartOut) begin
          start_cnt++;
          chk("start_while_busy", 64'(bus.firBusyIn), 64'd0);
          if (exp_frame_q.size() == 0) fail_now("unexpected_start");
          else chk("frame", bus.firDataOut, exp_frame_q.pop_front());
        end
        if (bus.resultValidOut) begin
          chk("sample_ready_in_emit", 64'(bus.sampleReadyOut), 64'd0);
          if (hold_pend) chk("held_stable", 64'(bus.resultOut), 64'(hold_val));
          if (bus.resultReadyIn) begin
            hold_pend = 1'b0;
            if (exp_res_q.size() == 0) fail_now("unexpected_result");
            else chk("result", 64'(bus.resultOut), 64'(exp_res_q.pop_front()));
          end else begin
            hold_pend = 1'b1;
            hold_val  = bus.resultOut;
          end
        end
      end
    end
  end

  task automatic send_one(input logic [15:0] s);
    int n;
    bus.sampleIn      = s;
    bus.sampleValidIn = 1'b1;
    n = 0;
    @(negedge clkIn);
    while (!bus.sampleReadyOut && n < 50) begin
      n++;
      @(negedge clkIn);
    end
    if (n >= 50) fail_now("sample_accept_timeout");
    @(posedge clkIn);
    #1;
  endtask

  task automatic send_frame(input logic [63:0] frame);
    exp_frame_q.push_back(frame);
    for (int i = 0; i < 4; i++) send_one(frame[16*i +: 16]);
    bus.sampleValidIn = 1'b0;
  endtask

  // Called while firStartOut is high; plays the filter and queues expected outputs.
  task automatic run_filter(input logic [127:0] words, input logic [63:0] exps);
    @(posedge clkIn);
    #1;
    chk("start_one_cycle", 64'(bus.firStartOut), 64'd0);
    for (int i = 0; i < 4; i++) exp_res_q.push_back(exps[63 - 16*i -: 16]);
    bus.firDataIn = words;
    bus.firDoneIn = 1'b1;
    @(posedge clkIn);
    #1;
    bus.firDoneIn = 1'b0;
    bus.firDataIn = '0;
    chk("valid_after_done", 64'(bus.resultValidOut), 64'd1);
  endtask

  task automatic drain(input bit toggle, input bit inject);
    int n;
    n = 0;
    while (n < 60) begin
      @(negedge clkIn);
      if (bus.sampleReadyOut && !bus.resultValidOut) break;
      @(posedge clkIn);
      #1;
      if (toggle) bus.resultReadyIn = ~bus.resultReadyIn;
      if (inject && n == 1) begin
        bus.firDataIn = {4{32'h1234_5678}};
        bus.firDoneIn = 1'b1;
      end
      if (inject && n == 2) bus.firDoneIn = 1'b0;
      n++;
    end
    if (n >= 60) fail_now("emit_timeout");
    @(posedge clkIn);
    #1;
    bus.resultReadyIn = 1'b1;
    chk("results_drained", 64'(exp_res_q.size()), 64'd0);
  endtask

  logic [63:0] round_exp;
  int          cnt0;

  initial begin
    bus.sampleIn      = '0;
    bus.sampleValidIn = 1'b0;
    bus.firBusyIn     = 1'b0;
    bus.firDoneIn     = 1'b0;
    bus.firDataIn     = '0;
    bus.resultReadyIn = 1'b1;
`ifdef FIR_STREAM_ROUND_EN
    round_exp = 64'h0001_0000_ffff_0002;
`else
    round_exp = 64'h0000_ffff_ffff_0002;
`endif

    // Reset values
    repeat (3) @(posedge clkIn);
    #1;
    chk("rst_start", 64'(bus.firStartOut), 64'd0);
    chk("rst_valid", 64'(bus.resultValidOut), 64'd0);
    chk("rst_frame", bus.firDataOut, 64'd0);
    chk("rst_result", 64'(bus.resultOut), 64'd0);
    nResetIn = 1'b1;
    #1;
    chk("rst_sample_ready", 64'(bus.sampleReadyOut), 64'd1);
    @(posedge clkIn);
    #1;

    // Frame packing, result order/scaling, exact EMIT length
    send_frame(64'h0004_0003_0002_0001);
    chk("start_after_last", 64'(bus.firStartOut), 64'd1);
    chk("no_ready_in_start", 64'(bus.sampleReadyOut), 64'd0);
    run_filter({32'h0000_8000, 32'h7fff_ffff, 32'h8000_0000, 32'h0001_0000},
               64'h0001_7fff_8000_0002);
    for (int i = 0; i < 4; i++) begin
      chk("emit_len_valid", 64'(bus.resultValidOut), 64'd1);
      @(posedge clkIn);
      #1;
    end
    chk("ready_after_emit", 64'(bus.sampleReadyOut), 64'd1);
    chk("valid_low_after_emit", 64'(bus.resultValidOut), 64'd0);
    chk("results_s1", 64'(exp_res_q.size()), 64'd0);

    // Rounding vs truncation
    send_frame(64'h8000_7fff_0000_ffff);
    run_filter({32'h0000_4000, 32'hffff_ffff, 32'hffff_8000, 32'h0001_0000}, round_exp);
    drain(1'b0, 1'b0);

    // Busy hold-off
    bus.firBusyIn = 1'b1;
    send_frame(64'h1111_2222_3333_4444);
    cnt0 = start_cnt;
    for (int i = 0; i < 5; i++) begin
      chk("busy_holdoff", 64'(bus.firStartOut), 64'd0);
      @(posedge clkIn);
      #1;
    end
    bus.firBusyIn = 1'b0;
    #1;
    chk("start_after_busy", 64'(bus.firStartOut), 64'd1);
    run_filter({32'h0001_8000, 32'h0002_0000, 32'hffff_0000, 32'h0002_8000},
               64'h0003_0004_fffe_0005);
    chk("single_start", 64'(start_cnt - cnt0), 64'd1);
    drain(1'b0, 1'b0);

    // Done outside WAIT ignored; backpressure with a stray done during EMIT
    bus.firDataIn = {4{32'h7fff_0000}};
    bus.firDoneIn = 1'b1;
    @(posedge clkIn);
    #1;
    bus.firDoneIn = 1'b0;
    chk("done_ignored_collect", 64'(bus.resultValidOut), 64'd0);
    chk("collect_still_ready", 64'(bus.sampleReadyOut), 64'd1);
    send_frame(64'h0a0b_0c0d_0e0f_0102);
    run_filter({32'h0003_0000, 32'hffff_8000, 32'h0000_0000, 32'h0004_0000},
               64'h0006_ffff_0000_0008);
    drain(1'b1, 1'b1);

    // Reset mid-frame, then mid-EMIT
    send_one(16'hdead);
    send_one(16'hbeef);
    nResetIn = 1'b0;
    #1;
    bus.sampleValidIn = 1'b0;
    chk("rst_mid_frame_data", bus.firDataOut, 64'd0);
    chk("rst_mid_frame_start", 64'(bus.firStartOut), 64'd0);
    @(posedge clkIn);
    #1;
    nResetIn = 1'b1;
    #1;
    chk("rst_mid_frame_ready", 64'(bus.sampleReadyOut), 64'd1);
    @(posedge clkIn);
    #1;
    send_frame(64'h0040_0030_0020_0010);
    bus.resultReadyIn = 1'b0;
    run_filter({32'h0001_0000, 32'h0001_0000, 32'h0001_0000, 32'h0001_0000},
               64'h0002_0002_0002_0002);
    @(posedge clkIn);
    #1;
    nResetIn = 1'b0;
    #1;
    exp_res_q.delete();
    chk("rst_emit_valid", 64'(bus.resultValidOut), 64'd0);
    chk("rst_emit_result", 64'(bus.resultOut), 64'd0);
    chk("rst_emit_frame", bus.firDataOut, 64'd0);
    @(posedge clkIn);
    #1;
    nResetIn          = 1'b1;
    bus.resultReadyIn = 1'b1;
    @(posedge clkIn);
    #1;
    send_frame(64'h0d0c_0b0a_0908_0706);
    run_filter({32'h0000_8000, 32'h7fff_ffff, 32'h8000_0000, 32'h0001_0000},
               64'h0001_7fff_8000_0002);
    drain(1'b0, 1'b0);
    chk("frames_all_started", 64'(exp_frame_q.size()), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
